multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock, rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port opcode  input  7  instruction bits [6:0] from instruction register.
REQ-004 SHALL have port funct3  input  3  instruction bits [14:12].
REQ-005 SHALL have port funct7b5  input  1  instruction bit 30.
REQ-006 SHALL have port mem_ready  input  1  memory completes current access this cycle.
REQ-007 SHALL have port br_taken  input  1  branch comparator result, valid in EXEC.
REQ-008 SHALL have port mem_req  output  1  memory access request, held until mem_ready.
REQ-009 SHALL have port mem_we  output  1  store when mem_req=1.
REQ-010 SHALL have port ir_write  output  1  load instruction register.
REQ-011 SHALL have port pc_write  output  1  update PC.
REQ-012 SHALL have port pc_src  output  1  0=PC+4, 1=ALU result.
REQ-013 SHALL have port ru_write  output  1  register-file write enable.
REQ-014 SHALL have port ru_data_src  output  2  00=ALU, 01=memory, 10=PC+4.
REQ-015 SHALL have port aluASrc  output  1  0=RU[rs1], 1=PC (drives muxaluA select).
REQ-016 SHALL have port aluBSrc  output  1  0=RU[rs2], 1=immediate.
REQ-017 SHALL have port alu_op  output  4  ALU operation code.
REQ-018 SHALL have port illegal  output  1  sticky; unsupported opcode seen.
REQ-019 SHALL have port state_o  output  3  current FSM state, debug.

Function
REQ-020 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs Moore-decoded from state and registered opcode fields.
REQ-021 FETCH: mem_req=1, mem_we=0; on mem_ready ir_write=1 same cycle, next DECODE; else stay FETCH.
REQ-022 DECODE: one cycle, no enables; unsupported opcode -> HALT, illegal=1; else EXEC.
REQ-023 EXEC: aluASrc=1 only for AUIPC, JAL, BRANCH; aluBSrc=1 for I-type, load, store, LUI, AUIPC, JAL, JALR.
REQ-024 EXEC next: load/store -> MEM; BRANCH -> FETCH with pc_write=1, pc_src=br_taken; all others -> WB.
REQ-025 MEM: mem_req=1, mem_we=1 for store; wait on mem_ready; store then -> FETCH with pc_write=1, pc_src=0; load then -> WB.
REQ-026 WB: ru_write=1, pc_write=1; pc_src=1 for JAL/JALR else 0; ru_data_src=01 load, 10 JAL/JALR, 00 otherwise; next FETCH.
REQ-027 alu_op SHALL be ADD for address/PC computations; R/I-type from {funct7b5,funct3}, funct7b5 ignored for I-type except SRAI.
REQ-028 Zero-wait latency SHALL be: R/I/LUI/AUIPC/JAL/JALR 4 cycles, load 5, store 4, branch 3; each mem_ready=0 cycle adds one.
REQ-029 HALT SHALL be absorbing; all enables 0; exit only by reset.
REQ-030 mem_ready asserted outside FETCH/MEM SHALL be ignored.
REQ-031 Exactly one pc_write pulse SHALL occur per retired instruction.

Reset
REQ-032 rst_n low SHALL asynchronously force FETCH, illegal=0, all enables 0, mid-access or mid-instruction.
REQ-033 After rst_n deasserts, first mem_req SHALL assert in the first cycle.

Configuration
REQ-034 MULTICYCLE_CTRL_INSTRET_EN defined: add output instret 32 bits, reset 0, +1 on each pc_write, wraps at 2^32-1 to 0.
REQ-035 Macro undefined: no instret port, no counter logic.

Structure
REQ-036 Shared package SHALL hold state enum, opcode constants, alu_op encodings, ru_data_src encodings.
REQ-037 One sub-module alu_decoder (opcode/funct3/funct7b5/state -> alu_op) is natural; FSM stays in top.

Verification
REQ-038 ADD x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXEC,WB; WB ru_write=1, pc_write=1, pc_src=0, alu_op=ADD.
REQ-039 LW opcode 0x03, mem_ready low 2 cycles in MEM -> 7 cycles total, ru_data_src=01 in WB.
REQ-040 BEQ opcode 0x63, br_taken=1 -> 3 cycles, EXEC aluASrc=1, pc_write=1, pc_src=1, no ru_write.
REQ-041 Opcode 0x7F -> DECODE then HALT, illegal=1, no further mem_req for 20 cycles.
REQ-042 rst_n low during MEM of SW -> mem_req drops immediately; FETCH on release.
REQ-043 With MULTICYCLE_CTRL_INSTRET_EN, 10 back-to-back ADDs -> instret=10.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// States, opcode constants, ALU op codes and writeback source codes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // ALU codes are {funct7b5, funct3} for the RV32I ops
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  // LUI result is the immediate passed straight through
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  localparam logic [1:0] RDS_ALU = 2'b00;
  localparam logic [1:0] RDS_MEM = 2'b01;
  localparam logic [1:0] RDS_PC4 = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode for the multicycle control unit.
// Outside EXEC/WB the ALU only ever forms addresses, so it adds.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [2:0] state,
  output logic [3:0] aluOp
);

  logic isAluState;
  logic sraBit;

  assign isAluState = (state == EXEC) || (state == WB);
  assign sraBit = funct7b5 & (funct3 == 3'b101);

  // Select ALU function from instruction class and funct fields
  always_comb begin
    aluOp = ALU_ADD;
    if (isAluState) begin
      unique case (1'b1)
        opcode == OP_REG: aluOp = {funct7b5, funct3};
        opcode == OP_IMM: aluOp = {sraBit, funct3};
        opcode == OP_LUI: aluOp = ALU_PASSB;
        default:          aluOp = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Define MULTICYCLE_CTRL_INSTRET_EN to add the 32-bit instret counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ru_write,
  output logic [1:0]  ru_data_src,
  output logic        aluASrc,
  output logic        aluBSrc,
  output logic [3:0]  alu_op,
  output logic        illegal,
  output logic [2:0]  state_o
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  state_t state;
  state_t nextState;
  logic   illegalQ;

  logic isLoad, isStore, isBranch, isJal, isJalr;
  logic isAuipc, isLui, isImm, isReg, isJump;
  logic supported, aSel, bSel;

  logic reqC, weC, irC, pcwC, pcsC, ruwC, aC, bC;
  logic [1:0] rdsC;

  assign isLoad   = opcode == OP_LOAD;
  assign isStore  = opcode == OP_STORE;
  assign isBranch = opcode == OP_BRANCH;
  assign isJal    = opcode == OP_JAL;
  assign isJalr   = opcode == OP_JALR;
  assign isAuipc  = opcode == OP_AUIPC;
  assign isLui    = opcode == OP_LUI;
  assign isImm    = opcode == OP_IMM;
  assign isReg    = opcode == OP_REG;
  assign isJump   = isJal | isJalr;

  assign supported = isLoad | isStore | isBranch
                   | isJump | isAuipc | isLui
                   | isImm | isReg;

  assign aSel = isAuipc | isJal | isBranch;
  assign bSel = isImm | isLoad | isStore | isLui
              | isAuipc | isJump;

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      illegalQ <= 1'b0;
    end else begin
      state <= nextState;
      if (state == DECODE && !supported)
        illegalQ <= 1'b1;
    end
  end

  // Next-state and control decode from state and IR fields
  always_comb begin
    nextState = state;
    reqC = 1'b0;
    weC  = 1'b0;
    irC  = 1'b0;
    pcwC = 1'b0;
    pcsC = 1'b0;
    ruwC = 1'b0;
    aC   = 1'b0;
    bC   = 1'b0;
    rdsC = RDS_ALU;
    unique case (state)
      FETCH: begin
        reqC = 1'b1;
        if (mem_ready) begin
          irC = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: nextState = supported ? EXEC : HALT;
      EXEC: begin
        aC = aSel;
        bC = bSel;
        if (isLoad || isStore) begin
          nextState = MEM;
        end else if (isBranch) begin
          pcwC = 1'b1;
          pcsC = br_taken;
          nextState = FETCH;
        end else begin
          nextState = WB;
        end
      end
      MEM: begin
        reqC = 1'b1;
        weC  = isStore;
        if (mem_ready) begin
          pcwC = isStore;
          nextState = isStore ? FETCH : WB;
        end
      end
      WB: begin
        // ALU selects held so the jump target/result stays valid
        aC   = aSel;
        bC   = bSel;
        ruwC = 1'b1;
        pcwC = 1'b1;
        pcsC = isJump;
        rdsC = isLoad ? RDS_MEM : (isJump ? RDS_PC4 : RDS_ALU);
        nextState = FETCH;
      end
      HALT: nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  alu_decoder uAluDec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .state    (state),
    .aluOp    (alu_op)
  );

  // Reset kills enables at once, even mid-access
  assign mem_req     = rst_n & reqC;
  assign mem_we      = rst_n & weC;
  assign ir_write    = rst_n & irC;
  assign pc_write    = rst_n & pcwC;
  assign pc_src      = rst_n & pcsC;
  assign ru_write    = rst_n & ruwC;
  assign aluASrc     = rst_n & aC;
  assign aluBSrc     = rst_n & bC;
  assign ru_data_src = rst_n ? rdsC : RDS_ALU;
  assign illegal     = illegalQ;
  assign state_o     = state;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instret <= 32'd0;
    else if (pc_write)
      instret <= instret + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Vector table, corner sequences, random run vs step-plan model.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       mem_ready;
  logic       br_taken;
  logic       mem_req, mem_we, ir_write, pc_write, pc_src;
  logic       ru_write, aluASrc, aluBSrc, illegal;
  logic [1:0] ru_data_src;
  logic [3:0] alu_op;
  logic [2:0] state_o;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [31:0] instret;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .funct3(funct3), .funct7b5(funct7b5),
    .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .ru_write(ru_write),
    .ru_data_src(ru_data_src), .aluASrc(aluASrc),
    .aluBSrc(aluBSrc), .alu_op(alu_op),
    .illegal(illegal), .state_o(state_o)
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7;
    int         lat;
    logic [3:0] op;
    logic       a;
    logic       b;
    logic [1:0] rds;
  } vec_t;

  vec_t vecs[13];

  // snapshots captured while an instruction runs
  logic       exA, exB, exPcw, exPcs, exRuw, fIr;
  logic [3:0] exOp, wbOp;
  logic       wbRuw, wbPcw, wbPcs;
  logic [1:0] wbRds;

  task automatic runInstr(input logic [6:0] o,
                          input logic [2:0] f,
                          input logic f7,
                          input logic br,
                          input int waits,
                          output int cyc,
                          output int pcw);
    int w;
    bit done;
    w = 0; cyc = 0; pcw = 0; done = 0;
    opcode = o; funct3 = f; funct7b5 = f7;
    br_taken = br;
    {exA, exB, exPcw, exPcs, exRuw, fIr} = '0;
    {wbRuw, wbPcw, wbPcs} = '0;
    exOp = '0; wbOp = '0; wbRds = '0;
    while (!done && cyc < 30) begin
      mem_ready = (state_o == MEM && w < waits)
                  ? 1'b0 : 1'b1;
      #1;
      if (pc_write) pcw++;
      if (state_o == FETCH && ir_write) fIr = 1'b1;
      if (state_o == MEM && !mem_ready) w++;
      if (state_o == EXEC) begin
        exA = aluASrc; exB = aluBSrc; exOp = alu_op;
        exPcw = pc_write; exPcs = pc_src;
        exRuw = ru_write;
      end
      if (state_o == WB) begin
        wbRuw = ru_write; wbPcw = pc_write;
        wbPcs = pc_src; wbRds = ru_data_src;
        wbOp = alu_op;
      end
      tick();
      cyc++;
      if (state_o == FETCH) done = 1;
    end
  endtask

  // model: plan of steps per instruction, from class rules
  typedef enum int {P_F, P_D, P_E, P_M, P_W} phase_e;

  function automatic logic [3:0] refOp(
      logic [6:0] o, logic [2:0] f, logic f7);
    if (o == OP_REG) return {f7, f3Fix(f)};
    if (o == OP_IMM) return (f == 3'd5) ? {f7, f} : {1'b0, f};
    if (o == OP_LUI) return ALU_PASSB;
    return ALU_ADD;
  endfunction

  function automatic logic [2:0] f3Fix(logic [2:0] f);
    return f;
  endfunction

  function automatic logic [16:0] expOut(
      phase_e ph, logic [6:0] o, logic [2:0] f,
      logic f7, logic rdy, logic br);
    logic [2:0] st;
    logic req, we, ir, pcw, pcs, ruw, a, b, jmp;
    logic [1:0] rds;
    logic [3:0] op;
    st = FETCH; req = 0; we = 0; ir = 0; pcw = 0;
    pcs = 0; ruw = 0; a = 0; b = 0; rds = 0;
    op = ALU_ADD;
    jmp = (o == OP_JAL) || (o == OP_JALR);
    case (ph)
      P_F: begin st = FETCH; req = 1; ir = rdy; end
      P_D: st = DECODE;
      P_E: begin
        st = EXEC;
        a = o inside {OP_AUIPC, OP_JAL, OP_BRANCH};
        b = o inside {OP_IMM, OP_LOAD, OP_STORE,
                      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
        if (o == OP_BRANCH) begin pcw = 1; pcs = br; end
        op = refOp(o, f, f7);
      end
      P_M: begin
        st = MEM; req = 1; we = (o == OP_STORE);
        pcw = rdy && (o == OP_STORE);
      end
      default: begin
        st = WB; ruw = 1; pcw = 1; pcs = jmp;
        rds = (o == OP_LOAD) ? 2'b01 : (jmp ? 2'b10 : 2'b00);
      end
    endcase
    return {st, req, we, ir, pcw, pcs, ruw, rds, a, b, op};
  endfunction

  logic [6:0] ops[9] = '{OP_LOAD, OP_IMM, OP_AUIPC,
                         OP_STORE, OP_REG, OP_LUI,
                         OP_BRANCH, OP_JALR, OP_JAL};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    int cyc, pcw, cnt, sum;
    phase_e plan[$];
    logic [16:0] act, ex, msk;
    int retired, pcwSeen, cycles;

    vecs[0]  = '{"add",  OP_REG, 3'd0, 1'b0, 4, ALU_ADD, 0, 0, 2'b00};
    vecs[1]  = '{"sub",  OP_REG, 3'd0, 1'b1, 4, ALU_SUB, 0, 0, 2'b00};
    vecs[2]  = '{"sra",  OP_REG, 3'd5, 1'b1, 4, ALU_SRA, 0, 0, 2'b00};
    vecs[3]  = '{"addi", OP_IMM, 3'd0, 1'b1, 4, ALU_ADD, 0, 1, 2'b00};
    vecs[4]  = '{"srai", OP_IMM, 3'd5, 1'b1, 4, ALU_SRA, 0, 1, 2'b00};
    vecs[5]  = '{"xori", OP_IMM, 3'd4, 1'b0, 4, ALU_XOR, 0, 1, 2'b00};
    vecs[6]  = '{"lw",   OP_LOAD, 3'd2, 1'b0, 5, ALU_ADD, 0, 1, 2'b01};
    vecs[7]  = '{"sw",   OP_STORE, 3'd2, 1'b0, 4, ALU_ADD, 0, 1, 2'b00};
    vecs[8]  = '{"beq",  OP_BRANCH, 3'd0, 1'b0, 3, ALU_ADD, 1, 0, 2'b00};
    vecs[9]  = '{"lui",  OP_LUI, 3'd3, 1'b1, 4, ALU_PASSB, 0, 1, 2'b00};
    vecs[10] = '{"auipc", OP_AUIPC, 3'd0, 1'b0, 4, ALU_ADD, 1, 1, 2'b00};
    vecs[11] = '{"jal",  OP_JAL, 3'd0, 1'b0, 4, ALU_ADD, 1, 1, 2'b10};
    vecs[12] = '{"jalr", OP_JALR, 3'd0, 1'b0, 4, ALU_ADD, 0, 1, 2'b10};

    // reset state
    rst_n = 0; opcode = OP_REG; funct3 = 0; funct7b5 = 0;
    mem_ready = 1; br_taken = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst mem_req", mem_req, 0);
    check("rst ir_write", ir_write, 0);
    check("rst state", state_o, FETCH);
    check("rst illegal", illegal, 0);
    mem_ready = 0;
    rst_n = 1;
    #1;
    check("first mem_req", mem_req, 1);
    check("first state", state_o, FETCH);
    @(negedge clk);

    // zero-wait vector table
    foreach (vecs[i]) begin
      runInstr(vecs[i].opc, vecs[i].f3, vecs[i].f7,
               1'b0, 0, cyc, pcw);
      check({vecs[i].name, " latency"}, cyc, vecs[i].lat);
      check({vecs[i].name, " pc_write n"}, pcw, 1);
      check({vecs[i].name, " ir_write"}, fIr, 1);
      check({vecs[i].name, " alu_op"}, exOp, vecs[i].op);
      check({vecs[i].name, " alu srcs"},
            {exA, exB}, {vecs[i].a, vecs[i].b});
      check({vecs[i].name, " wb rds"}, wbRds, vecs[i].rds);
    end

    // ADD x3,x1,x2 = 0x002081B3
    runInstr(7'h33, 3'd0, 1'b0, 1'b0, 0, cyc, pcw);
    check("add cycles", cyc, 4);
    check("add wb ru_write", wbRuw, 1);
    check("add wb pc_write", wbPcw, 1);
    check("add wb pc_src", wbPcs, 0);
    check("add wb alu_op", wbOp, ALU_ADD);

    // LW with two wait cycles in MEM
    runInstr(OP_LOAD, 3'd2, 1'b0, 1'b0, 2, cyc, pcw);
    check("lw wait cycles", cyc, 7);
    check("lw wb rds", wbRds, 2'b01);
    check("lw pc_write n", pcw, 1);

    // BEQ taken
    runInstr(OP_BRANCH, 3'd0, 1'b0, 1'b1, 0, cyc, pcw);
    check("beq cycles", cyc, 3);
    check("beq aluASrc", exA, 1);
    check("beq pc_write", exPcw, 1);
    check("beq pc_src", exPcs, 1);
    check("beq ru_write", exRuw, 0);

    // reset during SW memory phase
    opcode = OP_STORE; funct3 = 3'd2; mem_ready = 1;
    repeat (3) tick();
    mem_ready = 0;
    #1;
    check("sw in mem", state_o, MEM);
    check("sw mem_we", {mem_req, mem_we}, 2'b11);
    #1 rst_n = 0;
    #1;
    check("sw rst mem_req", {mem_req, mem_we}, 2'b00);
    check("sw rst state", state_o, FETCH);
    tick();
    rst_n = 1;
    #1;
    check("sw release", {state_o, mem_req}, {FETCH, 1'b1});
    @(negedge clk);

    // unsupported opcode halts
    opcode = 7'h7F; mem_ready = 1;
    tick();
    #1;
    check("ill decode", state_o, DECODE);
    tick();
    #1;
    check("ill halt", state_o, HALT);
    check("ill flag", illegal, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      #1;
      if (mem_req || ir_write || pc_write || ru_write) cnt++;
    end
    check("halt enables", cnt, 0);
    check("halt stays", {state_o, illegal}, {HALT, 1'b1});
    @(negedge clk);
    rst_n = 0;
    #1;
    check("ill cleared", illegal, 0);
    @(negedge clk);
    mem_ready = 0;
    rst_n = 1;
    @(negedge clk);

    // 10 back-to-back ADDs
    sum = 0;
    for (int i = 0; i < 10; i++) begin
      runInstr(OP_REG, 3'd0, 1'b0, 1'b0, 0, cyc, pcw);
      sum += pcw;
    end
    check("10 add pc_writes", sum, 10);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    check("instret 10", instret, 10);
`endif

    // random run against the step-plan model
    retired = 0; pcwSeen = 0; cycles = 0;
    for (int n = 0; n < 150 && cycles < 5000; n++) begin
      opcode = ops[$urandom_range(0, 8)];
      funct3 = 3'($urandom);
      funct7b5 = 1'($urandom);
      plan = '{P_F, P_D, P_E};
      if (opcode == OP_LOAD) begin
        plan.push_back(P_M); plan.push_back(P_W);
      end else if (opcode == OP_STORE) begin
        plan.push_back(P_M);
      end else if (opcode != OP_BRANCH) begin
        plan.push_back(P_W);
      end
      while (plan.size() > 0 && cycles < 5000) begin
        mem_ready = ($urandom_range(0, 2) != 0);
        br_taken = 1'($urandom);
        #1;
        ex = expOut(plan[0], opcode, funct3, funct7b5,
                    mem_ready, br_taken);
        msk = (plan[0] == P_E) ? 17'h1FFFF : 17'h1FFC0;
        act = {state_o, mem_req, mem_we, ir_write,
               pc_write, pc_src, ru_write, ru_data_src,
               aluASrc, aluBSrc, alu_op};
        check("rand outputs", act & msk, ex & msk);
        if (pc_write) pcwSeen++;
        if (!((plan[0] == P_F || plan[0] == P_M)
              && !mem_ready))
          void'(plan.pop_front());
        tick();
        cycles++;
      end
      if (plan.size() == 0) retired++;
    end
    check("rand retired", pcwSeen, retired);
    check("rand budget", cycles < 5000, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
